// File: rtl/oam_dma_if.sv
// ============================================================================
// Module      : oam_dma_if
// Description : Bus bundle between the CPU side and the OAM DMA engine.
//               Carries the CPU write decode inputs, cycle parity, memory
//               read data, and the DMA-driven bus outputs.
// Ports       : (signals only, no ports)
//               bus_addr/bus_din/bus_wr  - CPU write bus observed for trigger
//               odd_or_even              - CPU cycle parity, 1 = odd
//               mem_rdata                - memory read data (1-cycle latency)
//               dma_hijack/dma_addr/dma_dout/dma_wr/dma_done - DMA outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oam_dma_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic [7:0]  mem_rdata;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_wr;
  logic        dma_done;

  // DMA engine side
  modport slave (
    input  bus_addr, bus_din, bus_wr, odd_or_even, mem_rdata,
    output dma_hijack, dma_addr, dma_dout, dma_wr, dma_done
  );

  // CPU / system side
  modport master (
    output bus_addr, bus_din, bus_wr, odd_or_even, mem_rdata,
    input  dma_hijack, dma_addr, dma_dout, dma_wr, dma_done
  );
endinterface

`default_nettype wire

// File: rtl/oam_dma.sv
// ============================================================================
// Module      : oam_dma
// Description : Sprite OAM DMA engine. A CPU write to TRIGGER_ADDR latches a
//               source page, halts the CPU, optionally waits one alignment
//               cycle, then copies 256 bytes {page,00..FF} to OAM_DATA_ADDR
//               as alternating read/write cycles.
// Ports       : cpu_clk - single clock, rising edge
//               reset   - asynchronous active-high reset
//               bus     - oam_dma_if.slave bundle (CPU bus in, DMA bus out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic      cpu_clk,
  input logic      reset,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic        hijack_q;
  logic        done_q, done_d;

  logic [15:0] dma_addr_w;
  logic [7:0]  dma_dout_w;
  logic        dma_wr_w;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      hijack_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      // Hijack follows the next state so it rises the cycle after the trigger
      hijack_q <= (state_d != S_IDLE);
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    page_d     = page_q;
    done_d     = 1'b0;
    dma_addr_w = 16'h0000;
    dma_dout_w = 8'h00;
    dma_wr_w   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The CPU bus is only decoded here, so DMA's own writes never retrigger
        if (bus.bus_wr && (bus.bus_addr == TRIGGER_ADDR)) begin
          page_d  = bus.bus_din;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = bus.odd_or_even ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        dma_addr_w = {page_q, idx_q};
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        // Read data returns one cycle after the READ address, i.e. now
        dma_addr_w = OAM_DATA_ADDR;
        dma_dout_w = bus.mem_rdata;
        dma_wr_w   = 1'b1;
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.dma_hijack = hijack_q;
  assign bus.dma_done   = done_q;
  assign bus.dma_addr   = dma_addr_w;
  assign bus.dma_dout   = dma_dout_w;
  assign bus.dma_wr     = dma_wr_w;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// ============================================================================
// Module      : tb_oam_dma
// Description : Self-checking bench for oam_dma. A cycle-count model of the
//               transfer predicts every output each cycle; directed transfers
//               pin cycle counts and data, then a randomized phase runs with
//               bus noise, random parity and occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oam_dma;

  localparam logic [15:0] C_TRIG = 16'h4014;
  localparam logic [15:0] C_OAM  = 16'h2004;

  logic cpu_clk;
  logic reset;

  oam_dma_if bus_if ();

  oam_dma #(
    .TRIGGER_ADDR  (C_TRIG),
    .OAM_DATA_ADDR (C_OAM)
  ) u_dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .bus     (bus_if)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Source memory, one-cycle read latency
  logic [7:0] mem [0:65535];
  always @(posedge cpu_clk) bus_if.mem_rdata <= mem[bus_if.dma_addr];

  // ---------------- reference model ----------------
  // m_t counts cycles since the trigger edge (0 = halt cycle). After the
  // halt and optional align cycle, offset k alternates read (even) / write
  // (odd) with byte index k/2; the transfer ends after k = 511.
  bit         m_active;
  bit         m_align;
  bit         m_done;
  int         m_t;
  logic [7:0] m_page;

  always @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (bus_if.bus_wr && bus_if.bus_addr == C_TRIG) begin
          m_active <= 1'b1;
          m_t      <= 0;
          m_page   <= bus_if.bus_din;
        end
      end else begin
        if (m_t == 0) m_align <= bus_if.odd_or_even;
        if (m_t == 512 + int'(m_align)) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  // {hijack, done, wr, addr[15:0], dout[7:0]}
  function automatic logic [26:0] model_out();
    int k;
    logic [7:0]  ix;
    logic [15:0] a;
    logic [26:0] r;
    r = {m_active, m_done, 25'd0};
    if (m_active && m_t >= 1 + int'(m_align)) begin
      k  = m_t - 1 - int'(m_align);
      ix = 8'(k / 2);
      a  = {m_page, ix};
      if (k % 2 == 0) r[24:0] = {1'b0, a, 8'h00};
      else            r[24:0] = {1'b1, C_OAM, mem[a]};
    end
    return r;
  endfunction

  always @(negedge cpu_clk) begin
    chk("cycle_outputs",
        {5'd0, bus_if.dma_hijack, bus_if.dma_done, bus_if.dma_wr, bus_if.dma_addr, bus_if.dma_dout},
        {5'd0, model_out()});
  end

  // ---------------- directed transfer helper ----------------
  int         st_hij, st_wcnt, st_nread, st_bad, st_zc;
  logic [7:0] st_fw, st_lw;
  logic [15:0] st_fr, st_lr;
  bit         st_done;

  // Called at posedge+1 of a cycle where the DUT is idle (or pulsing done).
  // hook: 0 none, 1 retrigger at 100th write, 2 reset at write with idx 0x40.
  task automatic xfer(input logic [7:0] pg, input bit par, input int hook);
    st_hij = 0; st_wcnt = 0; st_nread = 0; st_bad = 0; st_zc = 0;
    st_fw = 8'h00; st_lw = 8'h00; st_fr = 16'h0000; st_lr = 16'h0000; st_done = 1'b0;
    bus_if.bus_wr      = 1'b1;
    bus_if.bus_addr    = C_TRIG;
    bus_if.bus_din     = pg;
    bus_if.odd_or_even = par;
    for (int c = 0; c < 700; c++) begin
      @(posedge cpu_clk); #1;
      bus_if.bus_wr   = 1'b0;
      bus_if.bus_addr = 16'h0000;
      bus_if.bus_din  = 8'h00;
      if (bus_if.dma_hijack) st_hij++;
      if (bus_if.dma_hijack && bus_if.dma_addr == 16'h0000) st_zc++;
      if (bus_if.dma_wr) begin
        st_wcnt++;
        if (st_wcnt == 1) st_fw = bus_if.dma_dout;
        st_lw = bus_if.dma_dout;
      end else if (bus_if.dma_hijack && bus_if.dma_addr != 16'h0000) begin
        st_nread++;
        if (st_nread == 1) st_fr = bus_if.dma_addr;
        st_lr = bus_if.dma_addr;
        if (bus_if.dma_addr[15:8] != pg) st_bad++;
      end
      if (bus_if.dma_done) begin
        st_done = 1'b1;
        break;
      end
      if (hook == 1 && bus_if.dma_wr && st_wcnt == 100) begin
        bus_if.bus_wr   = 1'b1;
        bus_if.bus_addr = C_TRIG;
        bus_if.bus_din  = 8'h03;
      end
      if (hook == 2 && bus_if.dma_wr && st_wcnt == 65) begin
        reset = 1'b1;
        #1;
        chk("abort_hijack", {31'd0, bus_if.dma_hijack}, 32'd0);
        chk("abort_wr",     {31'd0, bus_if.dma_wr},     32'd0);
        chk("abort_addr",   {16'd0, bus_if.dma_addr},   32'd0);
        chk("abort_dout",   {24'd0, bus_if.dma_dout},   32'd0);
        chk("abort_done",   {31'd0, bus_if.dma_done},   32'd0);
        return;
      end
    end
    chk("done_seen", {31'd0, st_done}, 32'd1);
  endtask

  int ndone;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    reset              = 1'b1;
    bus_if.bus_wr      = 1'b0;
    bus_if.bus_addr    = 16'h0000;
    bus_if.bus_din     = 8'h00;
    bus_if.odd_or_even = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1 reset = 1'b0;
    chk("rst_hijack", {31'd0, bus_if.dma_hijack}, 32'd0);
    chk("rst_addr",   {16'd0, bus_if.dma_addr},   32'd0);
    chk("rst_dout",   {24'd0, bus_if.dma_dout},   32'd0);
    chk("rst_wr",     {31'd0, bus_if.dma_wr},     32'd0);
    chk("rst_done",   {31'd0, bus_if.dma_done},   32'd0);
    @(posedge cpu_clk); #1;

    // Even alignment, page 02
    xfer(8'h02, 1'b0, 0);
    chk("even_hijack_len", st_hij,             32'd513);
    chk("even_writes",     st_wcnt,            32'd256);
    chk("even_first_data", {24'd0, st_fw},     32'h5A);
    chk("even_last_data",  {24'd0, st_lw},     32'hA5);
    chk("even_first_read", {16'd0, st_fr},     32'h0200);
    chk("even_last_read",  {16'd0, st_lr},     32'h02FF);
    chk("even_zero_addr",  st_zc,              32'd1);

    // Odd alignment, triggered in the done-pulse cycle of the previous one
    xfer(8'h02, 1'b1, 0);
    chk("odd_hijack_len",  st_hij,             32'd514);
    chk("odd_writes",      st_wcnt,            32'd256);
    chk("odd_first_read",  {16'd0, st_fr},     32'h0200);
    chk("odd_zero_addr",   st_zc,              32'd2);
    repeat (2) @(posedge cpu_clk); #1;

    // Page FF: no carry into page
    xfer(8'hFF, 1'b0, 0);
    chk("wrap_last_read",  {16'd0, st_lr},     32'hFFFF);
    chk("wrap_zero_addr",  st_zc,              32'd1);
    chk("wrap_hijack_len", st_hij,             32'd513);
    chk("wrap_bad_page",   st_bad,             32'd0);
    repeat (2) @(posedge cpu_clk); #1;

    // Retrigger mid-transfer is ignored
    xfer(8'h02, 1'b0, 1);
    chk("retrig_bad_page", st_bad,             32'd0);
    chk("retrig_reads",    st_nread,           32'd256);
    chk("retrig_writes",   st_wcnt,            32'd256);
    chk("retrig_last_data", {24'd0, st_lw},    32'hA5);
    repeat (2) @(posedge cpu_clk); #1;

    // Reset abort at write idx 0x40, then a full odd transfer
    xfer(8'h02, 1'b0, 2);
    chk("abort_at_write", st_wcnt, 32'd65);
    @(posedge cpu_clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (5) begin
      @(posedge cpu_clk); #1;
      if (bus_if.dma_done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    xfer(8'h02, 1'b1, 0);
    chk("post_abort_hijack", st_hij,  32'd514);
    chk("post_abort_writes", st_wcnt, 32'd256);
    repeat (2) @(posedge cpu_clk); #1;

    // Randomized phase: bus noise, random parity, occasional reset
    for (int c = 0; c < 4000; c++) begin
      @(posedge cpu_clk); #1;
      reset              = ($urandom_range(0, 1499) == 0);
      bus_if.bus_wr      = ($urandom_range(0, 3) == 0);
      bus_if.bus_addr    = ($urandom_range(0, 2) == 0) ? C_TRIG : 16'($urandom);
      bus_if.bus_din     = 8'($urandom);
      bus_if.odd_or_even = 1'($urandom);
    end
    @(posedge cpu_clk); #1;
    reset         = 1'b0;
    bus_if.bus_wr = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter TRIGGER_ADDR, default 16'h4014: the CPU-bus address whose write starts a transfer.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004: the PPU OAM data port address used for each DMA write.
REQ-003 SHALL have port cpu_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port bus_addr, input, 16: CPU bus address.
REQ-006 SHALL have port bus_din, input, 8: CPU write data.
REQ-007 SHALL have port bus_wr, input, 1: CPU write strobe.
REQ-008 SHALL have port odd_or_even, input, 1: CPU cycle parity, 1 = odd.
REQ-009 SHALL have port mem_rdata, input, 8: CPU memory read data, valid the cycle after its address is presented.
REQ-010 SHALL have port dma_hijack, output, 1: halts the CPU and gives the bus to DMA.
REQ-011 SHALL have port dma_addr, output, 16: DMA bus address.
REQ-012 SHALL have port dma_dout, output, 8: DMA write data.
REQ-013 SHALL have port dma_wr, output, 1: DMA write strobe.
REQ-014 SHALL have port dma_done, output, 1: one-cycle pulse at the end of a transfer.

Function
REQ-015 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE, plus an 8-bit index idx and an 8-bit page register.
REQ-016 In IDLE, SHALL leave IDLE only when bus_wr=1 and bus_addr==TRIGGER_ADDR at a clock edge; on that edge it latches page<=bus_din, sets idx<=0 and moves to HALT.
REQ-017 In HALT (one dummy cycle), SHALL sample odd_or_even: if 1, the next state is ALIGN; if 0, the next state is READ.
REQ-018 ALIGN SHALL last exactly one cycle and then move to READ.
REQ-019 In READ, SHALL drive dma_addr={page,idx} with dma_wr=0, then move to WRITE.
REQ-020 In WRITE, SHALL drive dma_addr=OAM_DATA_ADDR, dma_dout=mem_rdata and dma_wr=1.
REQ-021 At the end of WRITE: if idx==8'hFF, SHALL go to IDLE and pulse dma_done for the following cycle; otherwise idx<=idx+1 and go to READ.
REQ-022 dma_hijack SHALL be 1 in every state except IDLE, registered, so it rises the cycle after the trigger edge.
REQ-023 Total hijack length SHALL be 513 cycles (even alignment) or 514 cycles (odd alignment).
REQ-024 Address generation SHALL be {page,idx} with no carry into page; idx never wraps mid-transfer.
REQ-025 Outside READ and WRITE, SHALL drive dma_addr=16'h0000, dma_dout=8'h00 and dma_wr=0.
REQ-026 Outside WRITE, dma_dout SHALL be 8'h00.
REQ-027 Trigger writes while not in IDLE SHALL be ignored: page and idx unchanged, no restart.
REQ-028 A trigger in the same cycle as the dma_done pulse SHALL be accepted (IDLE is active then).
REQ-029 bus_* inputs SHALL NOT be decoded outside IDLE, so DMA-generated writes can never self-trigger.
REQ-030 Any page value 8'h00 through 8'hFF SHALL be legal.

Reset
REQ-031 Asserting reset SHALL immediately and asynchronously force state=IDLE, idx=0, page=0, dma_hijack=0, dma_wr=0, dma_addr=0, dma_dout=0 and dma_done=0.
REQ-032 Reset mid-transfer SHALL abort with no further writes, and SHALL NOT pulse dma_done.
REQ-033 After reset deasserts, the block SHALL be in IDLE and ready to accept a trigger on the next edge.

Verification
REQ-034 Even trigger: write 8'h02 to 16'h4014 with odd_or_even=0 in HALT, memory[16'h0200+i]=i^8'h5A -> 256 writes to 16'h2004 with data i^8'h5A in order, hijack high 513 cycles, one dma_done.
REQ-035 Odd trigger: same stimulus with odd_or_even=1 in HALT -> one extra ALIGN cycle, hijack high 514 cycles, first READ address 16'h0200.
REQ-036 Page wrap: page 8'hFF -> last read address 16'hFFFF, no access to 16'h0000, clean return to IDLE.
REQ-037 Re-trigger: write 8'h03 to 16'h4014 at the 100th WRITE of a page-8'h02 transfer -> ignored, all 256 reads from page 8'h02.
REQ-038 Reset abort: assert reset during the WRITE with idx=8'h40 -> outputs zero at once, no dma_done, and a new trigger afterwards runs a full 513/514-cycle transfer.
